// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage with RAW scoreboard and one output register toward execute.
// Optional writeback bypass into the operands is enabled by defining DECODE_WB_BYPASS_EN.
module decode_issue #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [31:0]     instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic            readEn,
   input  logic [XLEN-1:0] readOut1,
   input  logic [XLEN-1:0] readOut2,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [31:0]     ex_imm,
   output logic            ex_regwrite,
   output logic            ex_illegal
);
   logic [6:0]      opc;
   logic [4:0]      rd;
   logic            is_r, is_i, is_s, is_b, is_u, is_j;
   logic            uses1, uses2, regwrite, illegal;
   logic            byp1, byp2, hazard, slot_free, issue;
   logic [31:0]     imm;
   logic [XLEN-1:0] op1, op2;
   logic [NREG-1:0] pend, clr, set;

   assign opc = instr[6:0];
   assign rd  = instr[11:7];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign readEn = instr_valid & en;

   assign is_r = opc == 7'b0110011;
   assign is_i = opc == 7'b0010011 || opc == 7'b0000011 || opc == 7'b1100111;
   assign is_s = opc == 7'b0100011;
   assign is_b = opc == 7'b1100011;
   assign is_u = opc == 7'b0110111 || opc == 7'b0010111;
   assign is_j = opc == 7'b1101111;

   assign uses1    = is_r | is_i | is_s | is_b;
   assign uses2    = is_r | is_s | is_b;
   assign illegal  = !(is_r | is_i | is_s | is_b | is_u | is_j);
   assign regwrite = (is_r | is_i | is_u | is_j) & (rd != 5'd0);

   always_comb begin
      imm = is_i ? {{20{instr[31]}}, instr[31:20]} :
            is_s ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            is_b ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            is_u ? {instr[31:12], 12'b0} :
            is_j ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                   32'd0;
   end

`ifdef DECODE_WB_BYPASS_EN
   // A retiring producer forwards its data so the consumer issues in the same cycle.
   assign byp1 = wb_valid & (wb_rd == rs1) & pend[rs1];
   assign byp2 = wb_valid & (wb_rd == rs2) & pend[rs2];
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign op1 = byp1 ? wb_data : readOut1;
   assign op2 = byp2 ? wb_data : readOut2;

   assign hazard      = (uses1 & pend[rs1] & !byp1) | (uses2 & pend[rs2] & !byp2);
   assign slot_free   = !ex_valid | ex_ready;
   assign instr_ready = en & !hazard & slot_free;
   assign issue       = instr_valid & instr_ready;

   // The set is applied after the clear so a same-edge reissue of the register stays pending.
   assign clr = wb_valid ? (NREG'(1) << wb_rd) : '0;
   assign set = (issue & regwrite) ? (NREG'(1) << rd) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend        <= '0;
         ex_valid    <= 1'b0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7   <= '0;
         ex_rd       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_regwrite <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (en) begin
         pend <= ((pend & ~clr) | set) & ~NREG'(1);
         if (issue) begin
            ex_valid    <= 1'b1;
            ex_opcode   <= opc;
            ex_funct3   <= instr[14:12];
            ex_funct7   <= instr[31:25];
            ex_rd       <= rd;
            ex_rs1_val  <= op1;
            ex_rs2_val  <= op2;
            ex_imm      <= imm;
            ex_regwrite <= regwrite;
            ex_illegal  <= illegal;
         end else if (ex_ready & ex_valid) begin
            ex_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: table-driven decode checks plus hand sequences for hazard, backpressure and reset.
module tb_decode_issue;
   logic        clk = 1'b0;
   logic        reset, en, instr_valid, wb_valid, ex_ready;
   logic [31:0] instr, readOut1, readOut2, wb_data;
   logic [4:0]  wb_rd;
   logic        instr_ready, readEn, ex_valid, ex_regwrite, ex_illegal;
   logic [4:0]  rs1, rs2, ex_rd;
   logic [6:0]  ex_opcode, ex_funct7;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] instr, r1, r2, imm;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic        rw, ill;
   } vec_t;
   vec_t tv[10];

   decode_issue dut (
      .clk(clk), .reset(reset), .en(en), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rs1(rs1), .rs2(rs2), .readEn(readEn),
      .readOut1(readOut1), .readOut2(readOut2), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val),
      .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [4:0] r);
      wb_valid = 1'b1;
      wb_rd = r;
      cyc();
      wb_valid = 1'b0;
   endtask

   initial begin
      tv[0] = '{32'h00500093, 32'hA1, 32'hB1, 32'h5,        5'd1,  7'h13, 1'b1, 1'b0};
      tv[1] = '{32'h002081B3, 32'h11, 32'h22, 32'h0,        5'd3,  7'h33, 1'b1, 1'b0};
      tv[2] = '{32'h0020A423, 32'h33, 32'h44, 32'h8,        5'd8,  7'h23, 1'b0, 1'b0};
      tv[3] = '{32'hFE000EE3, 32'h55, 32'h66, 32'hFFFFFFFC, 5'd29, 7'h63, 1'b0, 1'b0};
      tv[4] = '{32'h00000000, 32'h0,  32'h0,  32'h0,        5'd0,  7'h00, 1'b0, 1'b1};
      tv[5] = '{32'h00100013, 32'h1,  32'h2,  32'h1,        5'd0,  7'h13, 1'b0, 1'b0};
      tv[6] = '{32'h123452B7, 32'h9,  32'hA,  32'h12345000, 5'd5,  7'h37, 1'b1, 1'b0};
      tv[7] = '{32'h008000EF, 32'hB,  32'hC,  32'h8,        5'd1,  7'h6F, 1'b1, 1'b0};
      tv[8] = '{32'hFFF00113, 32'hD,  32'hE,  32'hFFFFFFFF, 5'd2,  7'h13, 1'b1, 1'b0};
      tv[9] = '{32'hFE002E23, 32'h7,  32'h8,  32'hFFFFFFFC, 5'd28, 7'h23, 1'b0, 1'b0};
      reset = 1'b1; en = 1'b0; instr_valid = 1'b0; wb_valid = 1'b0; ex_ready = 1'b1;
      instr = '0; readOut1 = '0; readOut2 = '0; wb_data = '0; wb_rd = '0;
      repeat (2) cyc();
      reset = 1'b0;
      chk("reset ex_valid", 32'(ex_valid), 0);
      chk("reset ex_imm", ex_imm, 0);
      chk("en0 ready", 32'(instr_ready), 0);
      en = 1'b1;
      #1 chk("en1 ready", 32'(instr_ready), 1);

      for (int i = 0; i < 10; i++) begin
         instr = tv[i].instr; readOut1 = tv[i].r1; readOut2 = tv[i].r2; instr_valid = 1'b1;
         #1 chk("vec ready", 32'(instr_ready), 1);
         cyc();
         instr_valid = 1'b0;
         chk("vec ex_valid", 32'(ex_valid), 1);
         chk("vec opcode", 32'(ex_opcode), 32'(tv[i].opc));
         chk("vec rd", 32'(ex_rd), 32'(tv[i].rd));
         chk("vec imm", ex_imm, tv[i].imm);
         chk("vec regwrite", 32'(ex_regwrite), 32'(tv[i].rw));
         chk("vec illegal", 32'(ex_illegal), 32'(tv[i].ill));
         chk("vec rs1_val", ex_rs1_val, tv[i].r1);
         chk("vec rs2_val", ex_rs2_val, tv[i].r2);
         retire(tv[i].rd);
      end

      // RAW hazard on x1
      instr = 32'h00500093; instr_valid = 1'b1;
      cyc();
      instr = 32'h002081B3; readOut1 = 32'h11; readOut2 = 32'h22;
      #1 chk("raw rs1", 32'(rs1), 1);
      chk("raw rs2", 32'(rs2), 2);
      chk("raw readEn", 32'(readEn), 1);
      chk("raw stall", 32'(instr_ready), 0);
      cyc();
      chk("raw stall2", 32'(instr_ready), 0);
      chk("raw drained", 32'(ex_valid), 0);
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
`ifdef DECODE_WB_BYPASS_EN
      #1 chk("raw bypass ready", 32'(instr_ready), 1);
      cyc();
      wb_valid = 1'b0;
      chk("raw bypass rd", 32'(ex_rd), 3);
      chk("raw bypass rs1_val", ex_rs1_val, 32'hDEAD);
      chk("raw bypass rs2_val", ex_rs2_val, 32'h22);
`else
      #1 chk("raw wb same cycle", 32'(instr_ready), 0);
      cyc();
      wb_valid = 1'b0;
      #1 chk("raw wb next cycle", 32'(instr_ready), 1);
      cyc();
      chk("raw issued rd", 32'(ex_rd), 3);
      chk("raw issued rs1_val", ex_rs1_val, 32'h11);
`endif
      instr_valid = 1'b0;
      retire(5'd3);

      // backpressure
      ex_ready = 1'b0;
      instr = 32'hFFF00113; instr_valid = 1'b1;
      cyc();
      instr = 32'h123453B7;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp ready", 32'(instr_ready), 0);
         chk("bp ex_valid", 32'(ex_valid), 1);
         chk("bp ex_rd", 32'(ex_rd), 2);
         chk("bp ex_imm", ex_imm, 32'hFFFFFFFF);
         cyc();
      end
      ex_ready = 1'b1;
      #1 chk("bp release ready", 32'(instr_ready), 1);
      cyc();
      instr_valid = 1'b0;
      chk("bp next rd", 32'(ex_rd), 7);
      chk("bp next imm", ex_imm, 32'h12345000);
      retire(5'd2);
      retire(5'd7);

      // illegal opcode with rd=1 leaves x1 clear; x0 never pends
      instr = 32'h000000FF; instr_valid = 1'b1;
      cyc();
      chk("ill illegal", 32'(ex_illegal), 1);
      chk("ill regwrite", 32'(ex_regwrite), 0);
      instr = 32'h002081B3;
      #1 chk("ill no pend", 32'(instr_ready), 1);
      cyc();
      instr_valid = 1'b0;
      retire(5'd3);
      instr = 32'h00100013; instr_valid = 1'b1;
      cyc();
      instr = 32'h000001B3;
      #1 chk("x0 no pend", 32'(instr_ready), 1);
      cyc();
      instr_valid = 1'b0;
      retire(5'd3);

      // same-edge clear and set on x5
      instr = 32'h00100293; instr_valid = 1'b1;
      cyc();
      instr = 32'h00200293; wb_valid = 1'b1; wb_rd = 5'd5;
      #1 chk("same ready", 32'(instr_ready), 1);
      cyc();
      wb_valid = 1'b0;
      chk("same imm", ex_imm, 32'h2);
      instr = 32'h00028333;
      #1 chk("same still pend", 32'(instr_ready), 0);
      cyc();
      chk("same still pend2", 32'(instr_ready), 0);
      retire(5'd5);
      chk("same cleared", 32'(instr_ready), 1);
      instr_valid = 1'b0;
      retire(5'd6);

      // en low
      en = 1'b0; instr_valid = 1'b1;
      #1 chk("en0 ready2", 32'(instr_ready), 0);
      chk("en0 readEn", 32'(readEn), 0);
      en = 1'b1; instr_valid = 1'b0;

      // async reset mid-cycle with a held instruction
      ex_ready = 1'b0;
      instr = 32'h00500093; instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
      chk("rst pre ex_valid", 32'(ex_valid), 1);
      #2 reset = 1'b1;
      #1 chk("rst ex_valid", 32'(ex_valid), 0);
      chk("rst ex_rd", 32'(ex_rd), 0);
      chk("rst ex_imm", ex_imm, 0);
      #2 reset = 1'b0;
      cyc();
      instr = 32'h002081B3; instr_valid = 1'b1; ex_ready = 1'b1;
      #1 chk("rst sb clear", 32'(instr_ready), 1);
      cyc();
      instr_valid = 1'b0;
      chk("rst reissue rd", 32'(ex_rd), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- RV32I decode/issue stage directly upstream of the register file.
- Accepts one fetched instruction per cycle over a valid/ready handshake and drives the register file read addresses (rs1, rs2, readEn).
- Samples readOut1/readOut2, generates the immediate, and loads one output pipeline register toward execute.
- A 32-entry pending-write scoreboard stalls issue on RAW hazards until writeback retires the producing register.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (scoreboard depth)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
en  in  1  stage enable; low freezes all state, instr_ready=0
instr  in  32  fetched instruction
instr_valid  in  1  instr is valid
instr_ready  out  1  stage accepts instr this cycle
rs1  out  5  regfile read address 1 = instr[19:15]
rs2  out  5  regfile read address 2 = instr[24:20]
readEn  out  1  instr_valid & en
readOut1  in  32  regfile read data 1
readOut2  in  32  regfile read data 2
wb_valid  in  1  writeback retiring a register this cycle
wb_rd  in  5  register being retired
wb_data  in  32  data being written (used only with bypass)
ex_valid  out  1  output register holds an instruction
ex_ready  in  1  execute accepts output register
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7  out  7  instr[31:25]
ex_rd  out  5  destination register
ex_rs1_val  out  32  operand 1
ex_rs2_val  out  32  operand 2
ex_imm  out  32  sign-extended immediate
ex_regwrite  out  1  instruction writes rd (forced 0 when rd=0)
ex_illegal  out  1  unrecognised opcode

Behaviour:
- Register file read is combinational: rs1/rs2 are driven from instr in the same cycle; readOut1/readOut2 are sampled at the issuing edge.
- Reset (async): ex_valid=0, all ex_* fields=0, scoreboard=0. rs1/rs2/readEn/instr_ready are combinational from inputs and state. Reset mid-stall drops the held instruction; upstream re-presents it.
- Opcode classes:
  - R 0110011: uses rs1, rs2; writes rd.
  - I-ALU 0010011, LOAD 0000011, JALR 1100111: use rs1; write rd; I-immediate.
  - STORE 0100011: uses rs1, rs2; no write; S-immediate.
  - BRANCH 1100011: uses rs1, rs2; no write; B-immediate.
  - LUI 0110111, AUIPC 0010111: no reads; write rd; U-immediate.
  - JAL 1101111: no reads; writes rd; J-immediate.
  - Any other opcode: ex_illegal=1, regwrite=0, no hazard check, imm=0.
- Immediates are sign-extended from instr[31]; U-type = {instr[31:12], 12'b0}.
- hazard = (uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2]). pend[0] is hardwired 0.
- slot_free = !ex_valid | ex_ready.
- instr_ready = en & !hazard & slot_free.
- issue = instr_valid & instr_ready. On issue: load ex_* fields, ex_valid<=1, and set pend[rd] if regwrite.
- Drain: if ex_ready & ex_valid & !issue, ex_valid<=0. Fields hold their last values.
- ex_valid=1 with ex_ready=0: output register and all ex_* fields held stable.
- Scoreboard clear: wb_valid clears pend[wb_rd] at the edge.
- Same edge, same register, wb clear and issue set: the set wins; the register stays pending for the newer writer.
- Without bypass, a wb in cycle N does not unblock issue in cycle N (regfile written at edge); issue occurs in cycle N+1 at earliest.
- en=0: no issue, no drain, and scoreboard held.
- wb_valid with wb_rd=0, or for a non-pending register: no effect.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: a pending rsX matching wb_rd with wb_valid=1 is not a hazard. The operand is taken from wb_data instead of readOutX, so issue happens in cycle N.
- Undefined: no bypass; wb_data is unused.

Test Plan:
- Reset: assert reset mid-cycle with ex_valid=1 -> ex_valid=0 immediately, scoreboard clear, instr_ready=1 once en=1.
- addi x1,x0,5 (0x00500093) -> ex_rd=1, ex_imm=5, ex_regwrite=1, pend[1]=1. Next, add x3,x1,x2 (0x002081B3) -> instr_ready=0. Pulse wb_valid, wb_rd=1 -> add issues 1 cycle later (same cycle with DECODE_WB_BYPASS_EN, ex_rs1_val=wb_data).
- sw x2,8(x1) (0x0020A423) -> ex_imm=8, ex_regwrite=0. beq x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> instr_ready=0, ex_* stable; ex_ready=1 -> next instr issues the same edge.
- 0x00000000 -> ex_illegal=1, ex_regwrite=0, no pend bit set. addi x0,x0,1 -> pend[0] stays 0.
- Same-edge wb_rd=5 and issue of a writer to x5 -> pend[5]=1 afterwards.
